// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for param_sync_fifo and fifo_ram.
package fifo_pkg;
  localparam int FIFO_MIN_DEPTH = 4;
  localparam int FIFO_AF_MARGIN = 2;
  localparam int FIFO_AE_LVL = 2;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, registered read port; FIFO_SHOWAHEAD_EN reads through a next-address register instead.
module fifo_ram #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (wr_en) mem[wr_addr] <= data;
`ifdef FIFO_SHOWAHEAD_EN
  // addr_q tracks the read pointer after this edge so q shows the head word
  logic [AW-1:0] addr_q;
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) addr_q <= '0;
    else addr_q <= sclr ? '0 : rd_addr + AW'(rd_en);
  assign q = mem[addr_q];
`else
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) q <= '0;
    else if (sclr || rd_en) q <= sclr ? '0 : mem[rd_addr];
`endif
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: parameterised single-clock FIFO with level flags and sticky errors.
// Define FIFO_SHOWAHEAD_EN for first-word fall-through reads.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int ALMOST_FULL_LVL = DEPTH - FIFO_AF_MARGIN,
  parameter int ALMOST_EMPTY_LVL = FIFO_AE_LVL,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             sclr,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      usedw,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT = (AW+1)'(ALMOST_FULL_LVL);
  localparam logic [AW:0] AE_CNT = (AW+1)'(ALMOST_EMPTY_LVL);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt_nxt;
  logic wr_acc, rd_acc, wr_en, rd_en;
  // sclr is folded into the next state so the async reset branch stays the only reset path
  always_comb begin
    wr_acc = wrreq && (!full || rdreq);
    rd_acc = rdreq && !empty;
    wr_en = !sclr && wr_acc;
    rd_en = !sclr && rd_acc;
    cnt_nxt = sclr ? '0 : usedw + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  end
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= sclr ? '0 : wr_ptr + AW'(wr_acc);
      rd_ptr <= sclr ? '0 : rd_ptr + AW'(rd_acc);
      usedw <= cnt_nxt;
      full <= cnt_nxt == FULL_CNT;
      empty <= cnt_nxt == '0;
      almost_full <= cnt_nxt >= AF_CNT;
      almost_empty <= cnt_nxt <= AE_CNT;
      overflow <= !sclr && (overflow || (wrreq && !wr_acc));
      underflow <= !sclr && (underflow || (rdreq && !rd_acc));
    end
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock(clock),
    .aclr_n(aclr_n),
    .sclr(sclr),
    .wr_en(wr_en),
    .wr_addr(wr_ptr),
    .data(data),
    .rd_en(rd_en),
    .rd_addr(rd_ptr),
    .q(q)
  );
endmodule
